sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO, successor to the team's fixed 4-bit synchronous FIFO. Adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. It sits between any two blocks in one clock domain that need rate buffering. An optional first-word-fall-through read mode is selected by a macro.

---
 rtl/sync_fifo_param_if.sv | 36 +++
 rtl/sync_fifo_param.sv | 96 +++++++++
 tb/tb_sync_fifo_param.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: write/read handshake and status bundle
// for the parametrised single-clock FIFO.
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  clr;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, wr_en, data_in, rd_en,
    input  data_out, data_valid, count,
    input  full, empty, almost_full, almost_empty,
    input  overflow, underflow
  );

  modport slave (
    input  clr, wr_en, data_in, rd_en,
    output data_out, data_valid, count,
    output full, empty, almost_full, almost_empty,
    output overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with flags.
// Define SYNC_FIFO_PARAM_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input logic               clk,
  input logic               reset,
  sync_fifo_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  ovf_q;
  logic                  udf_q;
  logic                  full;
  logic                  empty;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_ok = bus.wr_en & ~full & ~bus.clr;
  assign rd_ok = bus.rd_en & ~empty & ~bus.clr;

  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  // storage array; contents survive flush and reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.data_in;
  end

  // pointers, occupancy and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      if (wr_ok && !rd_ok)
        count_q <= count_q + CW'(1);
      else if (rd_ok && !wr_ok)
        count_q <= count_q - CW'(1);
      if (bus.wr_en && full)  ovf_q <= 1'b1;
      if (bus.rd_en && empty) udf_q <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_PARAM_FWFT_EN
  // head word is shown directly; rd_en pops it
  assign bus.data_out   = empty ? '0 : mem[rd_ptr];
  assign bus.data_valid = ~empty;
`else
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dval_q;

  assign bus.data_out   = dout_q;
  assign bus.data_valid = dval_q;

  // registered read port; data holds between reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
      dval_q <= 1'b0;
    end else if (bus.clr) begin
      dval_q <= 1'b0;
    end else begin
      dval_q <= rd_ok;
      if (rd_ok) dout_q <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed checks of the parametrised
// FIFO in its default (registered read) build.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  sync_fifo_param_if #(.DATA_WIDTH(4), .DEPTH(8)) bus ();

  sync_fifo_param #(
    .DATA_WIDTH(4),
    .DEPTH(8),
    .AF_LEVEL(6),
    .AE_LEVEL(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(string tag, logic o, logic e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic chk4(string tag, logic [3:0] o, logic [3:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic idle();
    bus.clr   = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic push(logic [3:0] v);
    bus.wr_en   = 1'b1;
    bus.data_in = v;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic flush();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    idle();
    bus.data_in = '0;
    tick();
    tick();
    chk4("rst_count", bus.count, 4'd0);
    chk1("rst_empty", bus.empty, 1'b1);
    chk1("rst_ae", bus.almost_empty, 1'b1);
    chk1("rst_full", bus.full, 1'b0);
    chk1("rst_af", bus.almost_full, 1'b0);
    chk1("rst_ovf", bus.overflow, 1'b0);
    chk1("rst_udf", bus.underflow, 1'b0);
    chk1("rst_dval", bus.data_valid, 1'b0);
    chk4("rst_dout", bus.data_out, 4'd0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      push(4'(i));
      chk4("fill_count", bus.count, 4'(i + 1));
      chk1("fill_af", bus.almost_full, (i + 1) >= 6);
      chk1("fill_ae", bus.almost_empty, (i + 1) <= 2);
      chk1("fill_full", bus.full, i == 7);
    end

    push(4'd9);
    chk1("ovf_set", bus.overflow, 1'b1);
    chk4("ovf_count", bus.count, 4'd8);
    tick();
    chk1("ovf_sticky", bus.overflow, 1'b1);

    for (int i = 0; i < 8; i++) begin
      bus.rd_en = 1'b1;
      tick();
      chk4("drain_data", bus.data_out, 4'(i));
      chk1("drain_dval", bus.data_valid, 1'b1);
      chk4("drain_count", bus.count, 4'(7 - i));
      chk1("drain_empty", bus.empty, i == 7);
      chk1("drain_ae", bus.almost_empty, (7 - i) <= 2);
    end
    bus.rd_en = 1'b0;
    tick();
    chk1("hold_dval", bus.data_valid, 1'b0);
    chk4("hold_data", bus.data_out, 4'd7);
    chk1("hold_ovf", bus.overflow, 1'b1);
    chk1("hold_udf", bus.underflow, 1'b0);

    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk1("udf_set", bus.underflow, 1'b1);
    chk4("udf_count", bus.count, 4'd0);
    chk1("udf_dval", bus.data_valid, 1'b0);

    flush();
    chk1("clr_ovf", bus.overflow, 1'b0);
    chk1("clr_udf", bus.underflow, 1'b0);

    push(4'd1);
    push(4'd2);
    push(4'd3);
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.data_in = 4'd4;
    tick();
    idle();
    chk4("rw3_count", bus.count, 4'd3);
    chk4("rw3_data", bus.data_out, 4'd1);
    chk1("rw3_dval", bus.data_valid, 1'b1);
    for (int v = 5; v <= 9; v++) push(4'(v));
    chk1("rwf_full", bus.full, 1'b1);
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.data_in = 4'd15;
    tick();
    idle();
    chk4("rwf_count", bus.count, 4'd7);
    chk1("rwf_ovf", bus.overflow, 1'b1);
    chk4("rwf_data", bus.data_out, 4'd2);

    flush();
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.data_in = 4'd10;
    tick();
    idle();
    chk4("rwe_count", bus.count, 4'd1);
    chk1("rwe_udf", bus.underflow, 1'b1);
    chk1("rwe_dval", bus.data_valid, 1'b0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk4("rwe_data", bus.data_out, 4'd10);
    chk4("rwe_count0", bus.count, 4'd0);

    flush();
    for (int i = 0; i < 20; i++) begin
      bus.wr_en = 1'b1;
      bus.rd_en = (i > 0);
      bus.data_in = 4'((10 + i) % 16);
      tick();
      if (i > 0) begin
        chk4("wrap_data", bus.data_out, 4'((9 + i) % 16));
        chk4("wrap_count", bus.count, 4'd1);
      end
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk4("wrap_last", bus.data_out, 4'd13);
    chk1("wrap_empty", bus.empty, 1'b1);

    for (int v = 0; v < 5; v++) push(4'(v));
    chk4("fl_pre", bus.count, 4'd5);
    bus.clr = 1'b1;
    bus.wr_en = 1'b1;
    bus.data_in = 4'd3;
    tick();
    idle();
    chk4("fl_count", bus.count, 4'd0);
    chk1("fl_empty", bus.empty, 1'b1);
    chk1("fl_ae", bus.almost_empty, 1'b1);
    chk1("fl_af", bus.almost_full, 1'b0);
    chk1("fl_dval", bus.data_valid, 1'b0);

    push(4'd6);
    push(4'd7);
    push(4'd8);
    chk4("rf_count", bus.count, 4'd3);
    #2;
    reset = 1'b0;
    #1;
    chk4("ar_count", bus.count, 4'd0);
    chk1("ar_empty", bus.empty, 1'b1);
    chk1("ar_ae", bus.almost_empty, 1'b1);
    chk1("ar_full", bus.full, 1'b0);
    chk1("ar_af", bus.almost_full, 1'b0);
    chk1("ar_ovf", bus.overflow, 1'b0);
    chk1("ar_udf", bus.underflow, 1'b0);
    chk1("ar_dval", bus.data_valid, 1'b0);
    chk4("ar_dout", bus.data_out, 4'd0);
    tick();
    reset = 1'b1;
    tick();
    chk4("post_count", bus.count, 4'd0);
    push(4'd11);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk4("post_data", bus.data_out, 4'd11);
    chk1("post_dval", bus.data_valid, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
